// File: rtl/control_unit.sv
// Multicycle MIPS-style main controller: a Moore FSM that sequences fetch, decode
// and per-instruction execute/writeback, and produces all datapath control strobes.
module control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state;
  state_t next_state;

  logic pc_write;
  logic branch;
  logic ir_write;
  logic reg_write;
  logic mem_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BEQ;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // Decode state into strobes; only EXECUTE looks at an input (Funct).
  always_comb begin
    ALUControl = 3'b000;
    IorD       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    reg_write  = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = 3'b010;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = 3'b010;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b010;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // State-changing strobes are suppressed while reset is held.
  assign IRWrite  = ir_write & reset_n;
  assign RegWrite = reg_write & reset_n;
  assign MemWrite = mem_write & reset_n;
  assign PCEn     = (pc_write | (branch & Zero)) & reset_n;
  assign State    = state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-instruction expected output vectors are
// queued when an instruction is issued and compared cycle by cycle.
module tb_control_unit;

  logic       clk;
  logic       reset_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic [2:0] ALUControl;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
  } outs_t;

  outs_t expQ[$];
  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUControl(ALUControl), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic outs_t observed();
    outs_t o;
    o = {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
         ALUSrcA, ALUSrcB, PCSrc, ALUControl};
    return o;
  endfunction

  // Reference table of control outputs per state.
  function automatic outs_t model(int st, logic zero, logic [5:0] funct, logic inReset);
    outs_t e;
    e = '0;
    e.state = st[3:0];
    case (st)
      0: begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; e.aluc = 3'b010; end
      1: begin e.alusrcb = 2'b11; e.aluc = 3'b010; end
      2: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluc = 3'b010; end
      3: e.iord = 1;
      4: begin e.memtoreg = 1; e.regwrite = 1; end
      5: begin e.iord = 1; e.memwrite = 1; end
      6: begin
        e.alusrca = 1;
        case (funct)
          6'b100000: e.aluc = 3'b010;
          6'b100010: e.aluc = 3'b110;
          6'b100100: e.aluc = 3'b000;
          6'b100101: e.aluc = 3'b001;
          6'b101010: e.aluc = 3'b111;
          default:   e.aluc = 3'b010;
        endcase
      end
      7: begin e.regdst = 1; e.regwrite = 1; end
      8: begin e.alusrca = 1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = zero; end
      9: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluc = 3'b010; end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    if (inReset) begin
      e.irwrite = 0; e.pcen = 0; e.regwrite = 0; e.memwrite = 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from FETCH; inputs not sampled by a state are scrambled.
  task automatic applyStimulus(input string name, input logic [5:0] op,
                               input logic [5:0] funct, input logic zero);
    int path[$];
    outs_t e;
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
    foreach (path[i]) expQ.push_back(model(path[i], zero, funct, 1'b0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      Op    = (e.state == 4'd1 || e.state == 4'd2) ? op : 6'($urandom);
      Funct = (e.state == 4'd6) ? funct : 6'($urandom);
      Zero  = (e.state == 4'd8) ? zero : 1'($urandom);
      #1;
      checkOutput($sformatf("%s state%0d", name, e.state), 32'(observed()), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    Op = 6'b0;
    Funct = 6'b0;
    Zero = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset hold", 32'(observed()), 32'(model(0, 1'b0, 6'b0, 1'b1)));
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    applyStimulus("lw", 6'b100011, 6'b000000, 1'b0);
    applyStimulus("sw", 6'b101011, 6'b000000, 1'b1);
    applyStimulus("slt", 6'b000000, 6'b101010, 1'b0);
    applyStimulus("sub", 6'b000000, 6'b100010, 1'b0);
    applyStimulus("add", 6'b000000, 6'b100000, 1'b1);
    applyStimulus("and", 6'b000000, 6'b100100, 1'b0);
    applyStimulus("or", 6'b000000, 6'b100101, 1'b0);
    applyStimulus("rbad", 6'b000000, 6'b111111, 1'b0);
    applyStimulus("beq taken", 6'b000100, 6'b000000, 1'b1);
    applyStimulus("beq not", 6'b000100, 6'b000000, 1'b0);
    applyStimulus("addi", 6'b001000, 6'b000000, 1'b0);
    applyStimulus("j", 6'b000010, 6'b000000, 1'b0);
    applyStimulus("nop", 6'b111111, 6'b000000, 1'b0);

    // Asynchronous reset while an lw sits in MEMRD.
    Op = 6'b100011;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre-reset memrd", 32'(observed()), 32'(model(3, 1'b0, 6'b0, 1'b0)));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset", 32'(observed()), 32'(model(0, 1'b0, 6'b0, 1'b1)));
    @(posedge clk);
    #1;
    checkOutput("reset no regwrite", 32'(observed()), 32'(model(0, 1'b0, 6'b0, 1'b1)));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    applyStimulus("post-reset beq", 6'b000100, 6'b000000, 1'b1);
    applyStimulus("post-reset lw", 6'b100011, 6'b000000, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 Op  input  6  instruction opcode field, from instruction register.
REQ-005 Funct  input  6  R-type function field, from instruction register.
REQ-006 Zero  input  1  ALU result-equals-zero flag, same cycle.
REQ-007 ALUControl  output  3  ALU function select F: bit2 = invert B plus carry-in; bits1:0 = 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-008 IorD, MemWrite, IRWrite  output  1 each  memory address select, memory write enable, instruction register load.
REQ-009 RegDst, MemtoReg, RegWrite  output  1 each  register-file destination select, writeback data select, register write enable.
REQ-010 ALUSrcA  output  1 (0 = PC, 1 = register A); ALUSrcB  output  2 (00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2).
REQ-011 PCSrc  output  2 (00 = ALU result, 01 = ALUOut, 10 = jump target); PCEn  output  1  PC load enable.
REQ-012 State  output  4  current state code, for debug and verification.

Function
REQ-013 The block SHALL be a Moore FSM; all outputs except PCEn SHALL be decoded from the state only, and signals not listed for a state SHALL be 0.
REQ-014 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-015 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010; next state DECODE.
REQ-016 DECODE: ALUSrcB=11, ALUControl=010; next state by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP; any other Op -> FETCH (treated as NOP, no side effects).
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next state MEMRD if Op=100011, else MEMWR.
REQ-018 MEMRD: IorD=1, next state MEMWB; MEMWB: MemtoReg=1, RegWrite=1, next state FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1, next state FETCH.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010; next state ALUWB.
REQ-021 ALUWB: RegDst=1, RegWrite=1, next state FETCH.
REQ-022 BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, internal Branch=1; next state FETCH.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010, next state ADDIWB; ADDIWB: RegWrite=1, next state FETCH.
REQ-024 JUMP: PCSrc=10, PCWrite=1, next state FETCH.
REQ-025 PCEn SHALL equal PCWrite OR (Branch AND Zero), combinational from state and Zero.
REQ-026 Op and Funct SHALL be sampled only in the states listed above; changes in other states SHALL have no effect.
REQ-027 Instruction latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown Op 2.

Reset
REQ-028 reset_n low SHALL force State to FETCH immediately, without waiting for clk, from any state including mid-instruction.
REQ-029 While reset_n is low, the outputs SHALL hold FETCH values, with PCWrite, IRWrite, PCEn, RegWrite and MemWrite forced to 0.
REQ-030 The first rising clk after reset_n deasserts SHALL execute FETCH, with IRWrite=1 and PCEn=1, and then move to DECODE.

Verification
REQ-031 Release reset, Op=100011 -> State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-032 Op=000000, Funct=101010 -> in EXECUTE ALUControl=111; Funct=100010 -> 110; Funct=111111 -> 010; ALUWB has RegDst=1.
REQ-033 Op=000100 in BEQ: Zero=1 -> PCEn=1 and PCSrc=01; Zero=0 -> PCEn=0; both cases next state FETCH.
REQ-034 Op=101011 -> MEMWR has MemWrite=1 and IorD=1; Op=000010 -> JUMP has PCEn=1 and PCSrc=10.
REQ-035 Op=111111 in DECODE -> next state FETCH, and no RegWrite or MemWrite pulse occurs.
REQ-036 Assert reset_n low between clk edges while in MEMRD -> State=0 before the next edge; no RegWrite in the following cycle.
